lfsr_box_sel: RTL and testbench

LFSR_BOX_SEL -- requirements
Module: lfsr_box_sel

---
 rtl/lfsr_box_sel_if.sv | 32 +++
 rtl/lfsr_box_sel.sv | 159 +++++++++++++++
 tb/tb_lfsr_box_sel.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lfsr_box_sel_if.sv
// lfsr_box_sel_if
//   Groups the control and result signals of lfsr_box_sel into one bundle.
//   master: drives enable, seed_load, seed and req; observes the results.
//   slave : the selector itself; observes controls, drives busy, valid,
//           box, fallback and lfsr_state.
// Parameters
//   WIDTH : LFSR width (must match the selector's WIDTH)
//   K     : box index width, clog2(NUM_BOXES) of the selector
interface lfsr_box_sel_if #(
  parameter int WIDTH = 8,
  parameter int K     = 2
);
  logic             enable;
  logic             seed_load;
  logic [WIDTH-1:0] seed;
  logic             req;
  logic             busy;
  logic             valid;
  logic [K-1:0]     box;
  logic             fallback;
  logic [WIDTH-1:0] lfsr_state;

  modport master (
    output enable, seed_load, seed, req,
    input  busy, valid, box, fallback, lfsr_state
  );

  modport slave (
    input  enable, seed_load, seed, req,
    output busy, valid, box, fallback, lfsr_state
  );
endinterface

// File: rtl/lfsr_box_sel.sv
// lfsr_box_sel
//   Picks one of NUM_BOXES boxes using a Fibonacci-style LFSR. A draw
//   samples the low K bits of the LFSR once per cycle, rejecting values
//   that are out of range or (optionally) repeat the previous result, and
//   falls back to "previous box + 1" after MAX_TRIES rejects.
// Ports
//   clk    : system clock, rising edge
//   reset  : synchronous, active-high
//   bus    : lfsr_box_sel_if.slave
//            enable     in  free-run LFSR step enable while idle
//            seed_load  in  load seed this edge (zero seed loads 1)
//            seed       in  seed value
//            req        in  draw request, only sampled in IDLE
//            busy       out high while a draw is in progress
//            valid      out one-cycle pulse with a new result
//            box        out selected box, held between draws
//            fallback   out set with valid when the fallback rule produced box
//            lfsr_state out current LFSR register
module lfsr_box_sel #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] TAPS      = 8'hB8,
  parameter int               NUM_BOXES = 4,
  parameter int               NO_REPEAT = 1,
  parameter int               MAX_TRIES = 16
) (
  input  logic           clk,
  input  logic           reset,
  lfsr_box_sel_if.slave  bus
);

  localparam int K  = (NUM_BOXES > 1) ? $clog2(NUM_BOXES) : 1;
  localparam int TW = $clog2(MAX_TRIES + 1);

  // NUM_BOXES can equal 2^K, so range checks use one extra bit.
  localparam logic [K:0]    NUM_W    = (K+1)'(NUM_BOXES);
  localparam logic [K-1:0]  LAST_IDX = K'(NUM_BOXES - 1);
  localparam logic [TW-1:0] TRIES_W  = TW'(MAX_TRIES);

  typedef enum logic {
    IDLE,
    DRAW
  } state_t;

  state_t           state_reg,    state_next;
  logic [WIDTH-1:0] lfsr_reg,     lfsr_next;
  logic [TW-1:0]    try_reg,      try_next;
  logic [K-1:0]     box_reg,      box_next;
  logic [K-1:0]     last_box_reg, last_box_next;
  logic             prior_reg,    prior_next;
  logic             valid_reg,    valid_next;
  logic             fallback_reg, fallback_next;

  // Feedback: XOR of the tapped register bits.
  logic [WIDTH-1:0] tap_terms;
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_tap
    assign tap_terms[gi] = lfsr_reg[gi] & TAPS[gi];
  end

  logic             fb;
  logic [WIDTH-1:0] lfsr_stepped;
  logic [K-1:0]     cand;
  logic             in_range;
  logic             repeat_hit;
  logic             accept;
  logic [TW-1:0]    try_inc;
  logic             exhausted;
  logic [K-1:0]     wrap_box;
  logic             busy_int;

  assign fb           = ^tap_terms;
  assign lfsr_stepped = {lfsr_reg[WIDTH-2:0], fb};
  assign cand         = lfsr_reg[K-1:0];
  assign in_range     = ({1'b0, cand} < NUM_W);
  // Repeat suppression only applies once a result exists since reset.
  assign repeat_hit   = (NO_REPEAT != 0) && prior_reg && (cand == last_box_reg);
  assign accept       = in_range && !repeat_hit;
  assign try_inc      = try_reg + 1'b1;
  assign exhausted    = (try_inc == TRIES_W);
  assign wrap_box     = (last_box_reg == LAST_IDX) ? '0 : last_box_reg + 1'b1;
  assign busy_int     = (state_reg == DRAW);

  always_comb begin
    state_next    = state_reg;
    lfsr_next     = lfsr_reg;
    try_next      = try_reg;
    box_next      = box_reg;
    last_box_next = last_box_reg;
    prior_next    = prior_reg;
    valid_next    = 1'b0;
    fallback_next = 1'b0;

    // Seed load wins over stepping; all-zero would lock the LFSR up.
    if (bus.seed_load) begin
      lfsr_next = (bus.seed == '0) ? WIDTH'(1) : bus.seed;
    end else if (bus.enable || busy_int) begin
      lfsr_next = lfsr_stepped;
    end

    case (state_reg)
      IDLE: begin
        if (bus.req) begin
          state_next = DRAW;
          try_next   = '0;
        end
      end
      DRAW: begin
        if (accept) begin
          box_next      = cand;
          last_box_next = cand;
          prior_next    = 1'b1;
          valid_next    = 1'b1;
          state_next    = IDLE;
        end else if (exhausted) begin
          // Fallback result also becomes the reference for the next
          // no-repeat decision, so consecutive results always differ.
          box_next      = wrap_box;
          last_box_next = wrap_box;
          prior_next    = 1'b1;
          valid_next    = 1'b1;
          fallback_next = 1'b1;
          try_next      = '0;
          state_next    = IDLE;
        end else begin
          try_next = try_inc;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      lfsr_reg     <= WIDTH'(1);
      try_reg      <= '0;
      box_reg      <= '0;
      last_box_reg <= '0;
      prior_reg    <= 1'b0;
      valid_reg    <= 1'b0;
      fallback_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      lfsr_reg     <= lfsr_next;
      try_reg      <= try_next;
      box_reg      <= box_next;
      last_box_reg <= last_box_next;
      prior_reg    <= prior_next;
      valid_reg    <= valid_next;
      fallback_reg <= fallback_next;
    end
  end

  assign bus.busy       = busy_int;
  assign bus.valid      = valid_reg;
  assign bus.box        = box_reg;
  assign bus.fallback   = fallback_reg;
  assign bus.lfsr_state = lfsr_reg;

endmodule

// File: tb/tb_lfsr_box_sel.sv
// tb_lfsr_box_sel
//   Three selector instances: u0 defaults, u1 with NUM_BOXES=3, u2 with
//   NUM_BOXES=3 and MAX_TRIES=1. Stimulus pushes expected results (box,
//   fallback, cycle of the valid pulse) into per-instance queues; monitors
//   on the falling edge pop and compare whenever valid is high.
module tb_lfsr_box_sel;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0, rst1, rst2;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   nvalid [3] = '{0, 0, 0};

  always @(posedge clk) cyc <= cyc + 1;

  lfsr_box_sel_if #(.WIDTH(8), .K(2)) bus0 ();
  lfsr_box_sel_if #(.WIDTH(8), .K(2)) bus1 ();
  lfsr_box_sel_if #(.WIDTH(8), .K(2)) bus2 ();

  lfsr_box_sel #(.WIDTH(8), .TAPS(8'hB8), .NUM_BOXES(4), .NO_REPEAT(1), .MAX_TRIES(16))
    u0 (.clk(clk), .reset(rst0), .bus(bus0));
  lfsr_box_sel #(.WIDTH(8), .TAPS(8'hB8), .NUM_BOXES(3), .NO_REPEAT(1), .MAX_TRIES(16))
    u1 (.clk(clk), .reset(rst1), .bus(bus1));
  lfsr_box_sel #(.WIDTH(8), .TAPS(8'hB8), .NUM_BOXES(3), .NO_REPEAT(1), .MAX_TRIES(1))
    u2 (.clk(clk), .reset(rst2), .bus(bus2));

  typedef struct {
    logic [1:0] box;
    logic       fb;
    int         cyc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp_v);
    end
  endtask

  task automatic push(input int id, input logic [1:0] b, input logic f, input int c);
    exp_t e;
    e.box = b;
    e.fb  = f;
    e.cyc = c;
    case (id)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  function automatic int qsize(input int id);
    case (id)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  // ---------------- monitors ----------------
  logic [1:0] prev0, prev1, prev2;
  bit         have0 = 0, have1 = 0, have2 = 0;

  always @(negedge clk) begin : mon0
    exp_t e;
    if (rst0) have0 = 0;
    else if (bus0.valid === 1'b1) begin
      nvalid[0]++;
      if (q0.size() == 0) begin
        checks++; errors++;
        $display("FAIL u0_unexpected_valid: got box %0d, expected no valid", bus0.box);
      end else begin
        e = q0.pop_front();
        check("u0_box", 32'(bus0.box), 32'(e.box));
        check("u0_fallback", 32'(bus0.fallback), 32'(e.fb));
        check("u0_valid_cycle", cyc, e.cyc);
      end
      if (have0) check("u0_no_repeat", 32'(bus0.box != prev0), 1);
      prev0 = bus0.box;
      have0 = 1;
    end
  end

  always @(negedge clk) begin : mon1
    exp_t e;
    if (rst1) have1 = 0;
    else if (bus1.valid === 1'b1) begin
      nvalid[1]++;
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL u1_unexpected_valid: got box %0d, expected no valid", bus1.box);
      end else begin
        e = q1.pop_front();
        check("u1_box", 32'(bus1.box), 32'(e.box));
        check("u1_fallback", 32'(bus1.fallback), 32'(e.fb));
        check("u1_valid_cycle", cyc, e.cyc);
      end
      check("u1_box_range", 32'(bus1.box < 2'd3), 1);
      if (have1) check("u1_no_repeat", 32'(bus1.box != prev1), 1);
      prev1 = bus1.box;
      have1 = 1;
    end
  end

  always @(negedge clk) begin : mon2
    exp_t e;
    if (rst2) have2 = 0;
    else if (bus2.valid === 1'b1) begin
      nvalid[2]++;
      if (q2.size() == 0) begin
        checks++; errors++;
        $display("FAIL u2_unexpected_valid: got box %0d, expected no valid", bus2.box);
      end else begin
        e = q2.pop_front();
        check("u2_box", 32'(bus2.box), 32'(e.box));
        check("u2_fallback", 32'(bus2.fallback), 32'(e.fb));
        check("u2_valid_cycle", cyc, e.cyc);
      end
      check("u2_box_range", 32'(bus2.box < 2'd3), 1);
      if (have2) check("u2_no_repeat", 32'(bus2.box != prev2), 1);
      prev2 = bus2.box;
      have2 = 1;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int id, input logic en, input logic ld,
                       input logic [7:0] s, input logic r);
    case (id)
      0: begin bus0.enable = en; bus0.seed_load = ld; bus0.seed = s; bus0.req = r; end
      1: begin bus1.enable = en; bus1.seed_load = ld; bus1.seed = s; bus1.req = r; end
      default: begin bus2.enable = en; bus2.seed_load = ld; bus2.seed = s; bus2.req = r; end
    endcase
  endtask

  // One-edge request (optionally with seed load); c0 = cycle count after
  // the sampling edge.
  task automatic request(input int id, input logic ld, input logic [7:0] s, output int c0);
    drive(id, 1'b0, ld, s, 1'b1);
    step();
    drive(id, 1'b0, 1'b0, 8'h00, 1'b0);
    c0 = cyc;
  endtask

  task automatic drain(input int id, input string name);
    int n = 0;
    while (qsize(id) != 0 && n < 50) begin
      step();
      n++;
    end
    check(name, qsize(id), 0);
  endtask

  function automatic logic [7:0] mstep(input logic [7:0] v);
    return {v[6:0], ^(v & 8'hB8)};
  endfunction

  // ---------------- main sequence ----------------
  logic [7:0] seq [7] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11, 8'h23, 8'h47};

  initial begin : stim
    int c0;
    int zero_seen, early;
    int nv;
    logic [7:0] m_lfsr, s;
    logic [1:0] m_last, cand, rbox;
    bit         m_prior, ld, rfb;
    int         n, tries;

    rst0 = 1; rst1 = 1; rst2 = 1;
    drive(0, 0, 0, 8'h00, 0);
    drive(1, 0, 0, 8'h00, 0);
    drive(2, 0, 0, 8'h00, 0);
    step(); step();

    check("reset_lfsr", bus0.lfsr_state, 32'h01);
    check("reset_busy", bus0.busy, 0);
    check("reset_valid", bus0.valid, 0);
    check("reset_box", bus0.box, 0);
    check("reset_fallback", bus0.fallback, 0);
    check("reset_lfsr_u1", bus1.lfsr_state, 32'h01);

    // Free-running sequence and full period.
    drive(0, 1, 0, 8'h00, 0);
    rst0 = 0;
    check("seq_0", bus0.lfsr_state, 32'(seq[0]));
    for (int i = 1; i < 7; i++) begin
      step();
      check($sformatf("seq_%0d", i), bus0.lfsr_state, 32'(seq[i]));
    end
    zero_seen = 0;
    early = 0;
    for (int k = 7; k <= 255; k++) begin
      step();
      if (bus0.lfsr_state == 8'h00) zero_seen++;
      if (k < 255 && bus0.lfsr_state == 8'h01) early++;
    end
    check("period_return", bus0.lfsr_state, 32'h01);
    check("never_zero", zero_seen, 0);
    check("no_early_return", early, 0);
    drive(0, 0, 0, 8'h00, 0);

    // Directed draws on defaults.
    rst0 = 1; step(); rst0 = 0;
    request(0, 0, 8'h00, c0); push(0, 2'd1, 0, c0 + 1); drain(0, "u0_draw1_done");
    request(0, 0, 8'h00, c0); push(0, 2'd2, 0, c0 + 1); drain(0, "u0_draw2_done");
    request(0, 0, 8'h00, c0); push(0, 2'd0, 0, c0 + 1); drain(0, "u0_draw3_done");
    request(0, 0, 8'h00, c0); push(0, 2'd1, 0, c0 + 2); drain(0, "u0_draw4_done");
    check("u0_lfsr_after_draws", bus0.lfsr_state, 32'h23);

    // req held: second request lands in the cycle valid is high.
    drive(0, 0, 0, 8'h00, 1);
    step();
    c0 = cyc;
    push(0, 2'd3, 0, c0 + 1);
    push(0, 2'd2, 0, c0 + 4);
    step(); step();
    drive(0, 0, 0, 8'h00, 0);
    drain(0, "u0_backtoback_done");
    check("u0_lfsr_after_b2b", bus0.lfsr_state, 32'h1C);

    // Seed loads.
    drive(0, 0, 1, 8'h00, 0); step(); drive(0, 0, 0, 8'h00, 0);
    check("seed_zero_loads_one", bus0.lfsr_state, 32'h01);
    drive(0, 0, 1, 8'hA5, 0); step(); drive(0, 0, 0, 8'h00, 0);
    check("seed_load_a5", bus0.lfsr_state, 32'hA5);

    // Random regression against a small reference model.
    rst0 = 1; step(); rst0 = 0;
    m_lfsr = 8'h01; m_last = 2'd0; m_prior = 0;
    for (int it = 0; it < 40; it++) begin
      ld = 1'($urandom_range(0, 1));
      s  = 8'($urandom_range(0, 255));
      request(0, ld, s, c0);
      if (ld) m_lfsr = (s == 8'h00) ? 8'h01 : s;
      n = 0; tries = 0; rbox = 2'd0; rfb = 0;
      forever begin
        cand = m_lfsr[1:0];
        m_lfsr = mstep(m_lfsr);
        n++;
        if (!(m_prior && cand == m_last)) begin rbox = cand; rfb = 0; break; end
        tries++;
        if (tries == 16) begin rbox = m_last + 2'd1; rfb = 1; break; end
      end
      m_last = rbox;
      m_prior = 1;
      push(0, rbox, rfb, c0 + n);
      drain(0, "u0_random_done");
    end

    // NUM_BOXES=3: seed load and req on the same edge, out-of-range reject.
    rst1 = 0; step();
    request(1, 1, 8'h03, c0);
    push(1, 2'd2, 0, c0 + 2);
    check("u1_seed_with_req", bus1.lfsr_state, 32'h03);
    step();
    check("u1_lfsr_after_reject", bus1.lfsr_state, 32'h06);
    check("u1_busy_in_draw", bus1.busy, 1);
    drain(1, "u1_draw_done");
    check("u1_lfsr_after_accept", bus1.lfsr_state, 32'h0C);

    // Reset mid-draw overrides a same-edge seed load and request.
    request(1, 1, 8'h03, c0);
    step();
    nv = nvalid[1];
    rst1 = 1;
    drive(1, 0, 1, 8'h55, 1);
    step();
    drive(1, 0, 0, 8'h00, 0);
    check("u1_reset_busy", bus1.busy, 0);
    check("u1_reset_valid", bus1.valid, 0);
    check("u1_reset_lfsr", bus1.lfsr_state, 32'h01);
    rst1 = 0;
    step(); step(); step(); step();
    check("u1_no_valid_after_abort", nvalid[1], nv);
    check("u1_idle_after_abort", bus1.busy, 0);

    // MAX_TRIES=1: fallback rule including wrap-around.
    rst2 = 0; step();
    request(2, 1, 8'h03, c0); push(2, 2'd1, 1, c0 + 1); drain(2, "u2_fb1_done");
    request(2, 0, 8'h00, c0); push(2, 2'd2, 0, c0 + 1); drain(2, "u2_d2_done");
    request(2, 0, 8'h00, c0); push(2, 2'd0, 0, c0 + 1); drain(2, "u2_d3_done");
    request(2, 1, 8'h04, c0); push(2, 2'd1, 1, c0 + 1); drain(2, "u2_fb_repeat_done");
    request(2, 1, 8'h06, c0); push(2, 2'd2, 0, c0 + 1); drain(2, "u2_d5_done");
    request(2, 1, 8'h03, c0); push(2, 2'd0, 1, c0 + 1); drain(2, "u2_fb_wrap_done");

    step(); step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
